// File: rtl/alu_seq_core.sv
// alu_seq_core: registered WIDTH-bit ALU with valid/ready handshakes on both sides.
// Ops: and, or, xor, nor, add, sub, slt, sll. When SHIFT_ITER=1 an sll with a nonzero
// amount runs as a 1-bit/cycle iterative shifter; all other ops have latency 1.
// Optional feature macro: ALU_FLAGS_EN enables zero/carry/overflow; otherwise they read 0.
module alu_seq_core #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned SHIFT_ITER = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   acc_q;
  logic [SHAMT_W-1:0] count_q;

  logic [SHAMT_W-1:0] shamt;
  logic [WIDTH-1:0]   alu_res;
  logic [WIDTH-1:0]   shift_res;
  logic               accept;
  logic               is_iter;
  logic               load_now;
  logic               shift_done;

  assign shamt      = b[SHAMT_W-1:0];
  assign in_ready   = (state_q == StIdle) && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign is_iter    = (alu_op == 3'b111) && (SHIFT_ITER != 0) && (shamt != '0);
  assign load_now   = accept && !is_iter;
  assign shift_res  = acc_q << 1;
  assign shift_done = (state_q == StShift) && (count_q == SHAMT_W'(1));

  // Combinational result for every op that completes at the accept edge
  always_comb begin
    alu_res = '0;
    case (alu_op)
      3'b000:  alu_res = a & b;
      3'b001:  alu_res = a | b;
      3'b010:  alu_res = a ^ b;
      3'b011:  alu_res = ~(a | b);
      3'b100:  alu_res = a + b;
      3'b101:  alu_res = a - b;
      3'b110:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      // Iterative builds only reach here with shamt==0, so no barrel shifter is needed
      default: alu_res = (SHIFT_ITER != 0) ? a : (a << shamt);
    endcase
  end

  // Control FSM with registered result, out_valid and busy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      acc_q     <= '0;
      count_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (out_valid && out_ready) out_valid <= 1'b0;
          if (accept) begin
            if (is_iter) begin
              state_q   <= StShift;
              busy      <= 1'b1;
              acc_q     <= a;
              count_q   <= shamt;
              out_valid <= 1'b0;
            end else begin
              result    <= alu_res;
              out_valid <= 1'b1;
            end
          end
        end
        StShift: begin
          if (shift_done) begin
            // Final step is folded into the result load
            result    <= shift_res;
            out_valid <= 1'b1;
            busy      <= 1'b0;
            state_q   <= StIdle;
          end else begin
            acc_q   <= shift_res;
            count_q <= count_q - SHAMT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] add_ext;
  logic [WIDTH:0] sub_ext;
  logic           carry_d;
  logic           overflow_d;

  assign add_ext = {1'b0, a} + {1'b0, b};
  assign sub_ext = {1'b0, a} - {1'b0, b};

  // Carry/overflow next values; only add and sub produce nonzero flags
  always_comb begin
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    if (alu_op == 3'b100) begin
      carry_d    = add_ext[WIDTH];
      overflow_d = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
    end else if (alu_op == 3'b101) begin
      carry_d    = sub_ext[WIDTH];
      overflow_d = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
    end
  end

  // Flags load alongside result and hold with it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
    end else if (load_now) begin
      zero     <= (alu_res == '0);
      carry    <= carry_d;
      overflow <= overflow_d;
    end else if (shift_done) begin
      zero     <= (shift_res == '0);
      carry    <= 1'b0;
      overflow <= 1'b0;
    end
  end
`else
  assign zero     = 1'b0;
  assign carry    = 1'b0;
  assign overflow = 1'b0;
`endif

endmodule
